// File: rtl/bram1_fifo_ctrl.sv
// bram1_fifo_ctrl: ready/valid FIFO built around one external single-port BRAM1.
// Reads take priority over writes; a small register output buffer (OB) hides the
// BRAM read latency so the dequeue side can stream from registered data.
module bram1_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PIPELINED  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENQ_VALID,
  input  logic [DATA_WIDTH-1:0] ENQ_DATA,
  output logic                  ENQ_READY,
  output logic                  DEQ_VALID,
  output logic [DATA_WIDTH-1:0] DEQ_DATA,
  input  logic                  DEQ_READY,
  output logic [ADDR_WIDTH+1:0] COUNT,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LAT   = 1 + PIPELINED;
  localparam int unsigned OB_N  = LAT + 1;
  localparam int unsigned OB_CW = $clog2(OB_N + 1);
  localparam int unsigned MW    = ADDR_WIDTH + 1;
  localparam int unsigned CW    = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [MW-1:0]         mem_cnt_q, mem_cnt_d;
  logic [LAT-1:0]        vld_sr_q, vld_sr_d;
  logic [OB_CW-1:0]      ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH-1:0] ob_q [OB_N];
  logic [DATA_WIDTH-1:0] ob_d [OB_N];

  logic [OB_CW-1:0]      inflight_c;
  logic [OB_CW:0]        resv_c;
  logic [OB_CW-1:0]      cap_idx_c;
  logic                  rd_go_c;
  logic                  wr_go_c;
  logic                  cap_c;
  logic                  pop_c;

  // Number of BRAM reads still travelling through the latency pipe
  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight_c = inflight_c + OB_CW'(vld_sr_q[i]);
    end
  end

  // A read is issued only when OB has a reserved slot for its data
  assign resv_c    = (OB_CW+1)'(ob_cnt_q) + (OB_CW+1)'(inflight_c);
  assign rd_go_c   = !RST && (mem_cnt_q != '0) && (resv_c < (OB_CW+1)'(OB_N));
  assign ENQ_READY = !RST && (mem_cnt_q != MW'(DEPTH)) && !rd_go_c;
  assign wr_go_c   = ENQ_VALID && ENQ_READY;
  assign cap_c     = vld_sr_q[LAT-1];
  assign DEQ_VALID = !RST && (ob_cnt_q != '0);
  assign DEQ_DATA  = ob_q[0];
  assign pop_c     = DEQ_VALID && DEQ_READY;
  assign COUNT     = RST ? '0 : CW'(mem_cnt_q) + CW'(inflight_c) + CW'(ob_cnt_q);

  // BRAM port arbitration: one operation per cycle, reads first
  always_comb begin
    BRAM_EN   = 1'b0;
    BRAM_WE   = 1'b0;
    BRAM_ADDR = '0;
    BRAM_DI   = '0;
    if (rd_go_c) begin
      BRAM_EN   = 1'b1;
      BRAM_ADDR = rd_ptr_q;
    end else if (wr_go_c) begin
      BRAM_EN   = 1'b1;
      BRAM_WE   = 1'b1;
      BRAM_ADDR = wr_ptr_q;
      BRAM_DI   = ENQ_DATA;
    end
  end

  // Next-state for pointers, occupancy, latency pipe and output buffer
  always_comb begin
    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(wr_go_c);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(rd_go_c);
    mem_cnt_d = mem_cnt_q + MW'(wr_go_c) - MW'(rd_go_c);

    vld_sr_d    = '0;
    vld_sr_d[0] = rd_go_c;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end

    // Pop shifts the buffer toward the head; capture lands behind the last valid entry
    ob_d = ob_q;
    if (pop_c) begin
      for (int unsigned i = 0; i < OB_N - 1; i++) begin
        ob_d[i] = ob_q[i+1];
      end
    end
    cap_idx_c = ob_cnt_q - OB_CW'(pop_c);
    if (cap_c) begin
      for (int unsigned i = 0; i < OB_N; i++) begin
        if (OB_CW'(i) == cap_idx_c) begin
          ob_d[i] = BRAM_DO;
        end
      end
    end
    ob_cnt_d = ob_cnt_q + OB_CW'(cap_c) - OB_CW'(pop_c);
  end

  // State registers; reset discards in-flight reads and buffered words
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      vld_sr_q  <= '0;
      ob_cnt_q  <= '0;
      for (int unsigned i = 0; i < OB_N; i++) begin
        ob_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      vld_sr_q  <= vld_sr_d;
      ob_cnt_q  <= ob_cnt_d;
      ob_q      <= ob_d;
    end
  end

endmodule

// File: tb/tb_bram1_fifo_ctrl.sv
// Testbench for bram1_fifo_ctrl: one instance per read latency, each with a BRAM1 model.
module tb_bram1_fifo_ctrl;

  logic       clk;
  logic       rst;

  logic       enq_valid0, enq_ready0, deq_valid0, deq_ready0, bram_en0, bram_we0;
  logic [7:0] enq_data0, deq_data0, bram_di0, bram_do0;
  logic [3:0] bram_addr0;
  logic [5:0] count0;

  logic       enq_valid1, enq_ready1, deq_valid1, deq_ready1, bram_en1, bram_we1;
  logic [7:0] enq_data1, deq_data1, bram_di1, bram_do1;
  logic [3:0] bram_addr1;
  logic [5:0] count1;

  int n_checks;
  int n_fail;

  bram1_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PIPELINED(0)) u_dut0 (
    .CLK(clk), .RST(rst),
    .ENQ_VALID(enq_valid0), .ENQ_DATA(enq_data0), .ENQ_READY(enq_ready0),
    .DEQ_VALID(deq_valid0), .DEQ_DATA(deq_data0), .DEQ_READY(deq_ready0),
    .COUNT(count0),
    .BRAM_EN(bram_en0), .BRAM_WE(bram_we0), .BRAM_ADDR(bram_addr0),
    .BRAM_DI(bram_di0), .BRAM_DO(bram_do0)
  );

  bram1_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PIPELINED(1)) u_dut1 (
    .CLK(clk), .RST(rst),
    .ENQ_VALID(enq_valid1), .ENQ_DATA(enq_data1), .ENQ_READY(enq_ready1),
    .DEQ_VALID(deq_valid1), .DEQ_DATA(deq_data1), .DEQ_READY(deq_ready1),
    .COUNT(count1),
    .BRAM_EN(bram_en1), .BRAM_WE(bram_we1), .BRAM_ADDR(bram_addr1),
    .BRAM_DI(bram_di1), .BRAM_DO(bram_do1)
  );

  // BRAM1 models (write-first DO); instance 1 has an extra output register
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [7:0] do0_s, do1_s, do1_p;

  always @(posedge clk) begin
    if (bram_en0) begin
      if (bram_we0) begin
        mem0[bram_addr0] <= bram_di0;
        do0_s            <= bram_di0;
      end else begin
        do0_s <= mem0[bram_addr0];
      end
    end
    if (bram_en1) begin
      if (bram_we1) begin
        mem1[bram_addr1] <= bram_di1;
        do1_s            <= bram_di1;
      end else begin
        do1_s <= mem1[bram_addr1];
      end
    end
    do1_p <= do1_s;
  end

  assign bram_do0 = do0_s;
  assign bram_do1 = do1_p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    enq_valid0 = 1'b0; enq_data0 = 8'h00; deq_ready0 = 1'b0;
    enq_valid1 = 1'b0; enq_data1 = 8'h00; deq_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (deq_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid0: got %b expected 0", deq_valid0); end
    n_checks++; if (bram_en0 !== 1'b0) begin n_fail++; $display("FAIL reset_bram_en0: got %b expected 0", bram_en0); end
    n_checks++; if (count0 !== 6'd0) begin n_fail++; $display("FAIL reset_count0: got %0d expected 0", count0); end
    n_checks++; if (enq_ready0 !== 1'b0) begin n_fail++; $display("FAIL reset_enq_ready0: got %b expected 0", enq_ready0); end
    n_checks++; if (deq_valid1 !== 1'b0 || count1 !== 6'd0 || bram_en1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut1: got valid=%b count=%0d en=%b expected 0/0/0", deq_valid1, count1, bram_en1);
    end
    rst = 1'b0; #1;
    n_checks++; if (enq_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready0: got %b expected 1", enq_ready0); end
    n_checks++; if (bram_we0 !== 1'b0) begin n_fail++; $display("FAIL reset_release_we0: got %b expected 0", bram_we0); end
  endtask

  task automatic test_single();
    @(negedge clk); enq_valid0 = 1'b1; enq_data0 = 8'hA5; deq_ready0 = 1'b1; #1;
    n_checks++; if (bram_en0 !== 1'b1 || bram_we0 !== 1'b1 || bram_addr0 !== 4'd0 || bram_di0 !== 8'hA5) begin
      n_fail++; $display("FAIL single_write: got en=%b we=%b addr=%0d di=%h expected 1/1/0/a5", bram_en0, bram_we0, bram_addr0, bram_di0);
    end
    @(negedge clk); enq_valid0 = 1'b0; #1;
    n_checks++; if (count0 !== 6'd1) begin n_fail++; $display("FAIL single_count_e1: got %0d expected 1", count0); end
    n_checks++; if (bram_en0 !== 1'b1 || bram_we0 !== 1'b0 || bram_addr0 !== 4'd0) begin
      n_fail++; $display("FAIL single_read_issue: got en=%b we=%b addr=%0d expected 1/0/0", bram_en0, bram_we0, bram_addr0);
    end
    @(negedge clk); #1;
    n_checks++; if (count0 !== 6'd1 || deq_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL single_e2: got count=%0d valid=%b expected 1/0", count0, deq_valid0);
    end
    @(negedge clk); #1;
    n_checks++; if (deq_valid0 !== 1'b1 || deq_data0 !== 8'hA5 || count0 !== 6'd1) begin
      n_fail++; $display("FAIL single_e3: got valid=%b data=%h count=%0d expected 1/a5/1", deq_valid0, deq_data0, count0);
    end
    @(negedge clk); #1;
    n_checks++; if (deq_valid0 !== 1'b0 || count0 !== 6'd0) begin
      n_fail++; $display("FAIL single_e4: got valid=%b count=%0d expected 0/0", deq_valid0, count0);
    end
    deq_ready0 = 1'b0;
  endtask

  task automatic test_fill();
    int sent;
    int maxc;
    sent = 0; maxc = 0; deq_ready0 = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      enq_valid0 = (sent < 24);
      enq_data0  = 8'(sent);
      #1;
      if (int'(count0) > maxc) maxc = int'(count0);
      if (enq_valid0 && enq_ready0) sent++;
    end
    n_checks++; if (sent != 18) begin n_fail++; $display("FAIL fill_accepted: got %0d expected 18", sent); end
    n_checks++; if (count0 !== 6'd18) begin n_fail++; $display("FAIL fill_count: got %0d expected 18", count0); end
    n_checks++; if (maxc != 18) begin n_fail++; $display("FAIL fill_max_count: got %0d expected 18", maxc); end
    n_checks++; if (enq_ready0 !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b expected 0", enq_ready0); end
    n_checks++; if (deq_valid0 !== 1'b1 || deq_data0 !== 8'h00) begin
      n_fail++; $display("FAIL fill_head: got valid=%b data=%h expected 1/00", deq_valid0, deq_data0);
    end
    enq_valid0 = 1'b0;
  endtask

  task automatic test_stream();
    int got;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 18; cyc++) begin
      @(negedge clk); enq_valid0 = 1'b0; deq_ready0 = 1'b1; #1;
      if (deq_valid0) begin
        n_checks++; if (deq_data0 !== 8'(got)) begin
          n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", got, deq_data0, 8'(got));
        end
        got++;
      end
    end
    n_checks++; if (got != 18) begin n_fail++; $display("FAIL stream_words: got %0d expected 18", got); end
    @(negedge clk); deq_ready0 = 1'b0; #1;
    n_checks++; if (count0 !== 6'd0 || deq_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL stream_empty: got count=%0d valid=%b expected 0/0", count0, deq_valid0);
    end
  endtask

  task automatic test_backpressure();
    int sent;
    int got;
    logic stall_prev;
    logic [7:0] hold;
    sent = 0; got = 0; stall_prev = 1'b0; hold = 8'h00;
    for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
      @(negedge clk);
      enq_valid0 = (sent < 40);
      enq_data0  = 8'(32'h80 + sent);
      deq_ready0 = ((cyc % 2) == 1);
      #1;
      if (cyc == 0) begin
        n_checks++; if (bram_we0 !== 1'b1 || bram_addr0 !== 4'd3) begin
          n_fail++; $display("FAIL bp_wrapped_wr_addr: got we=%b addr=%0d expected 1/3", bram_we0, bram_addr0);
        end
      end
      if (stall_prev) begin
        n_checks++; if (deq_valid0 !== 1'b1 || deq_data0 !== hold) begin
          n_fail++; $display("FAIL bp_stall_stable: got valid=%b data=%h expected 1/%h", deq_valid0, deq_data0, hold);
        end
      end
      if (enq_valid0 && enq_ready0) sent++;
      if (deq_valid0 && deq_ready0) begin
        n_checks++; if (deq_data0 !== 8'(32'h80 + got)) begin
          n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", got, deq_data0, 8'(32'h80 + got));
        end
        got++;
      end
      stall_prev = deq_valid0 && !deq_ready0;
      hold       = deq_data0;
    end
    n_checks++; if (got != 40 || sent != 40) begin
      n_fail++; $display("FAIL bp_totals: got sent=%0d recv=%0d expected 40/40", sent, got);
    end
    @(negedge clk); enq_valid0 = 1'b0; deq_ready0 = 1'b0;
  endtask

  task automatic test_pipelined();
    int sent;
    int got;
    int maxc;
    @(negedge clk); enq_valid1 = 1'b1; enq_data1 = 8'hA5; deq_ready1 = 1'b1; #1;
    n_checks++; if (bram_we1 !== 1'b1 || bram_addr1 !== 4'd0) begin
      n_fail++; $display("FAIL pipe_write: got we=%b addr=%0d expected 1/0", bram_we1, bram_addr1);
    end
    @(negedge clk); enq_valid1 = 1'b0; #1;
    n_checks++; if (count1 !== 6'd1) begin n_fail++; $display("FAIL pipe_count_e1: got %0d expected 1", count1); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_checks++; if (deq_valid1 !== 1'b0 || count1 !== 6'd1) begin
      n_fail++; $display("FAIL pipe_e3: got valid=%b count=%0d expected 0/1", deq_valid1, count1);
    end
    @(negedge clk); #1;
    n_checks++; if (deq_valid1 !== 1'b1 || deq_data1 !== 8'hA5 || count1 !== 6'd1) begin
      n_fail++; $display("FAIL pipe_e4: got valid=%b data=%h count=%0d expected 1/a5/1", deq_valid1, deq_data1, count1);
    end
    @(negedge clk); deq_ready1 = 1'b0; #1;
    n_checks++; if (deq_valid1 !== 1'b0 || count1 !== 6'd0) begin
      n_fail++; $display("FAIL pipe_e5: got valid=%b count=%0d expected 0/0", deq_valid1, count1);
    end

    sent = 0; maxc = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      enq_valid1 = (sent < 24);
      enq_data1  = 8'(32'h40 + sent);
      #1;
      if (int'(count1) > maxc) maxc = int'(count1);
      if (enq_valid1 && enq_ready1) sent++;
    end
    n_checks++; if (sent != 19 || count1 !== 6'd19 || maxc != 19) begin
      n_fail++; $display("FAIL pipe_fill: got sent=%0d count=%0d max=%0d expected 19/19/19", sent, count1, maxc);
    end
    enq_valid1 = 1'b0;

    got = 0;
    for (int cyc = 0; cyc < 100 && got < 19; cyc++) begin
      @(negedge clk); deq_ready1 = 1'b1; #1;
      if (deq_valid1) begin
        n_checks++; if (deq_data1 !== 8'(32'h40 + got)) begin
          n_fail++; $display("FAIL pipe_drain[%0d]: got %h expected %h", got, deq_data1, 8'(32'h40 + got));
        end
        got++;
      end
    end
    n_checks++; if (got != 19) begin n_fail++; $display("FAIL pipe_drain_words: got %0d expected 19", got); end
    @(negedge clk); deq_ready1 = 1'b0; #1;
    n_checks++; if (count1 !== 6'd0) begin n_fail++; $display("FAIL pipe_empty: got %0d expected 0", count1); end
  endtask

  task automatic test_reset_midstream();
    int sent;
    logic prev_rd;
    logic rd;
    logic found;
    logic seen;
    sent = 0; deq_ready1 = 1'b0;
    for (int cyc = 0; cyc < 30 && sent < 6; cyc++) begin
      @(negedge clk);
      enq_valid1 = 1'b1;
      enq_data1  = 8'(32'h60 + sent);
      #1;
      if (enq_ready1) sent++;
    end
    prev_rd = 1'b0; found = 1'b0;
    for (int cyc = 0; cyc < 30 && !found; cyc++) begin
      @(negedge clk); enq_valid1 = 1'b0; deq_ready1 = 1'b1; #1;
      rd = bram_en1 && !bram_we1;
      if (prev_rd && rd) found = 1'b1;
      prev_rd = rd;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_setup: got two_reads=%b expected 1", found); end

    @(negedge clk); rst = 1'b1; deq_ready1 = 1'b0; #1;
    n_checks++; if (count1 !== 6'd0 || deq_valid1 !== 1'b0 || enq_ready1 !== 1'b0 || bram_en1 !== 1'b0) begin
      n_fail++; $display("FAIL rst_during: got count=%0d valid=%b ready=%b en=%b expected 0/0/0/0", count1, deq_valid1, enq_ready1, bram_en1);
    end
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (count1 !== 6'd0 || deq_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: got count=%0d valid=%b expected 0/0", count1, deq_valid1);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk); #1;
      n_checks++; if (deq_valid1 !== 1'b0 || count1 !== 6'd0) begin
        n_fail++; $display("FAIL rst_late_data[%0d]: got valid=%b count=%0d expected 0/0", cyc, deq_valid1, count1);
      end
    end

    @(negedge clk); enq_valid1 = 1'b1; enq_data1 = 8'h3C; deq_ready1 = 1'b1; #1;
    n_checks++; if (enq_ready1 !== 1'b1 || bram_we1 !== 1'b1 || bram_addr1 !== 4'd0) begin
      n_fail++; $display("FAIL rst_first_write: got ready=%b we=%b addr=%0d expected 1/1/0", enq_ready1, bram_we1, bram_addr1);
    end
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk); enq_valid1 = 1'b0; #1;
      if (deq_valid1) begin
        seen = 1'b1;
        n_checks++; if (deq_data1 !== 8'h3C) begin n_fail++; $display("FAIL rst_first_word: got %h expected 3c", deq_data1); end
      end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_first_word_timeout: got valid=0 expected 1"); end
    @(negedge clk); deq_ready1 = 1'b0; #1;
    n_checks++; if (count1 !== 6'd0) begin n_fail++; $display("FAIL rst_final_count: got %0d expected 0", count1); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_backpressure();
    test_pipelined();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bram1_fifo_ctrl.md
Name: bram1_fifo_ctrl

Overview:
- Controller that turns one external single-port BRAM1 instance into a ready/valid FIFO for the LVDS echo datapath.
- Sits between the LVDS receive/deserialiser stage and the echo transmit stage.
- Drives BRAM1's EN/WE/ADDR/DI and consumes its DO.
- Hides BRAM read latency with a small register output buffer so DEQ_DATA can stream at one word per cycle.

Parameters:
- ADDR_WIDTH, 4, BRAM address width; BRAM depth is DEPTH = 2**ADDR_WIDTH (instance MEMSIZE must equal DEPTH).
- DATA_WIDTH, 8, word width.
- PIPELINED, 0, must match the BRAM1 instance setting; read latency L = 1 + PIPELINED clock edges.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- ENQ_VALID  input  1  producer has a word.
- ENQ_DATA  input  DATA_WIDTH  word to store.
- ENQ_READY  output  1  controller accepts the word this cycle.
- DEQ_VALID  output  1  DEQ_DATA holds the oldest word.
- DEQ_DATA  output  DATA_WIDTH  head word.
- DEQ_READY  input  1  consumer takes the head word.
- COUNT  output  ADDR_WIDTH+2  total words held (BRAM + in flight + output buffer).
- BRAM_EN  output  1  to BRAM1 EN.
- BRAM_WE  output  1  to BRAM1 WE.
- BRAM_ADDR  output  ADDR_WIDTH  to BRAM1 ADDR.
- BRAM_DI  output  DATA_WIDTH  to BRAM1 DI.
- BRAM_DO  input  DATA_WIDTH  from BRAM1 DO.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- State:
  - wr_ptr, rd_ptr: ADDR_WIDTH bits, wrap mod DEPTH.
  - mem_cnt: 0..DEPTH, words written but not yet read.
  - L-bit valid shift register tracking in-flight reads; inflight = its popcount.
  - Output buffer OB: register FIFO of L+1 entries, ob_cnt.
- Read issue (rd_go), a function of registered state only: mem_cnt != 0 && (ob_cnt + inflight) < L+1.
- Port arbitration, one BRAM op per cycle, reads have priority:
  - ENQ_READY = !RST && (mem_cnt != DEPTH) && !rd_go.
  - rd_go: BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=rd_ptr, push 1 into the valid shift register, rd_ptr++.
  - Otherwise, on ENQ_VALID && ENQ_READY: BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=wr_ptr, BRAM_DI=ENQ_DATA, wr_ptr++.
  - Idle: BRAM_EN=0; BRAM_WE, BRAM_ADDR and BRAM_DI are don't-care but held at 0.
- mem_cnt update: +1 on write, -1 on read issue. A write and a read never occur in the same cycle.
- Capture: when the shift-register output bit is 1, BRAM_DO is pushed into OB at that edge. The read is thus issued at edge E and captured at edge E+L.
- OB space reservation guarantees a capture never overflows OB.
- Dequeue:
  - DEQ_VALID = ob_cnt != 0; DEQ_DATA = OB head.
  - Pop on DEQ_VALID && DEQ_READY.
  - A pop and a capture in the same edge are legal; ob_cnt is unchanged and ordering is preserved.
  - DEQ_DATA is stable while DEQ_VALID && !DEQ_READY.
- COUNT = mem_cnt + inflight + ob_cnt, registered consistency each cycle. Maximum is DEPTH + L + 1.
- Latency:
  - Empty FIFO, word accepted at edge E0: read issues at E0+1, captured at E0+1+L, DEQ_VALID high after that edge.
  - That is 2 edges for PIPELINED=0 and 3 for PIPELINED=1.
  - Sustained throughput is 1 word/cycle on the dequeue side once OB is primed.
- Ordering: strict FIFO across pointer wrap. A read only targets addresses whose write completed at an earlier edge, so there is no read/write hazard.
- Full: mem_cnt == DEPTH gives ENQ_READY=0. ENQ_DATA is ignored when not ready.
- Writer may be stalled while the consumer drains continuously and mem_cnt != 0; this is accepted behaviour.
- Reset:
  - RST high at an edge clears pointers, counts, the shift register and OB.
  - In-flight reads are discarded; BRAM_DO from them is ignored.
  - During and after reset, until the first non-reset edge: DEQ_VALID=0, BRAM_EN=0, BRAM_WE=0, COUNT=0; ENQ_READY=0 while RST is high.
  - BRAM contents are not cleared.

Test Plan:
- PIPELINED=0, empty, enqueue 0xA5 at edge 1, DEQ_READY=1 -> BRAM write at addr 0, read issue edge 2, DEQ_VALID=1 with DEQ_DATA=0xA5 after edge 3; COUNT goes 1,1,1,0.
- Fill: DEQ_READY=0, push 0x00..0x17 continuously (DEPTH=16, L=1) -> first two words land in OB; ENQ_READY drops when mem_cnt=16; COUNT=18 max; no word is lost.
- Stream: after the fill, DEQ_READY=1 -> 18 words dequeued in order 0x00..0x11 on consecutive cycles; wr_ptr/rd_ptr wrap past 15 correctly.
- Backpressure: toggle DEQ_READY every cycle while enqueuing 40 words -> output sequence is identical to input and DEQ_DATA is stable during stalls.
- PIPELINED=1 -> repeat the first scenario; DEQ_VALID rises one edge later (after edge 4) and OB holds up to 3 words.
- Reset mid-stream: assert RST for one edge while 2 reads are in flight -> COUNT=0, DEQ_VALID=0 next cycle; late BRAM_DO values never appear on DEQ_DATA; next enqueue 0x3C appears first.
